// File: rtl/program_sequencer_if.sv
// program_sequencer_if: control, program-memory and processor-side signals of the
// instruction sequencer; master is the sequencer, slave is its environment.
interface program_sequencer_if #(
   parameter int unsigned ADDR_W = 5
);
   logic              start;
   logic              step_mode;
   logic              step;
   logic              halt_req;
   logic [ADDR_W-1:0] mem_addr;
   logic [8:0]        mem_rdata;
   logic [8:0]        proc_din;
   logic              proc_run;
   logic              proc_done;
   logic [ADDR_W-1:0] pc_out;
   logic [15:0]       instr_count;
   logic              busy;
   logic              halted;
   logic              timeout_err;
   modport master (
      input  start, step_mode, step, halt_req, mem_rdata, proc_done,
      output mem_addr, proc_din, proc_run, pc_out, instr_count, busy, halted, timeout_err
   );
   modport slave (
      output start, step_mode, step, halt_req, mem_rdata, proc_done,
      input  mem_addr, proc_din, proc_run, pc_out, instr_count, busy, halted, timeout_err
   );
endinterface

// File: rtl/program_sequencer.sv
// program_sequencer: fetches 9-bit instructions from a synchronous-read program memory
// and feeds them to the processor over DIN/RUN, advancing the PC on DONE.
module program_sequencer #(
   parameter int unsigned ADDR_W     = 5,
   parameter logic [2:0]  END_OPCODE = 3'b000,
   parameter logic [2:0]  MVI_OPCODE = 3'b010,
   parameter int unsigned TIMEOUT    = 7
) (
   input logic                 clk,
   input logic                 resetn,
   program_sequencer_if.master bus
);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   typedef enum logic [3:0] {
      IDLE, FETCH_I, LATCH_I, FETCH_IMM, LATCH_IMM, ISSUE, EXEC, STEP_WAIT, HALTED
   } state_t;
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d, mem_addr_q, mem_addr_d;
   logic [8:0]        ir_q, ir_d, imm_q, imm_d, din_q, din_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic              run_q, run_d, busy_q, busy_d, halted_q, halted_d;
   logic              err_q, err_d, pend_q, pend_d;
   logic              is_mvi, stop;
   assign is_mvi = ir_q[8:6] == MVI_OPCODE;
   assign stop   = pend_q || bus.halt_req;
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      mem_addr_d = mem_addr_q;
      ir_d       = ir_q;
      imm_d      = imm_q;
      din_d      = din_q;
      cnt_d      = cnt_q;
      timer_d    = timer_q;
      err_d      = err_q;
      pend_d     = pend_q || (bus.halt_req && busy_q);
      case (state_q)
         IDLE, HALTED: if (bus.start) begin
            state_d = FETCH_I;
            pc_d    = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
            pend_d  = 1'b0;
         end
         FETCH_I: state_d = LATCH_I;
         LATCH_I: begin
            ir_d = bus.mem_rdata;
            if (bus.mem_rdata[8:6] == END_OPCODE || stop) state_d = HALTED;
            else if (bus.mem_rdata[8:6] == MVI_OPCODE) begin
               state_d    = FETCH_IMM;
               mem_addr_d = pc_q + 1'b1;
            end else begin
               state_d = ISSUE;
               din_d   = bus.mem_rdata;
            end
         end
         FETCH_IMM: state_d = LATCH_IMM;
         LATCH_IMM: begin
            imm_d = bus.mem_rdata;
            if (stop) state_d = HALTED;
            else begin
               state_d = ISSUE;
               din_d   = ir_q;
            end
         end
         ISSUE: begin
            state_d = EXEC;
            timer_d = '0;
            din_d   = is_mvi ? imm_q : ir_q;
         end
         // an in-flight instruction always retires or times out before a halt takes effect
         EXEC: if (bus.proc_done) begin
            pc_d    = pc_q + (is_mvi ? ADDR_W'(2) : ADDR_W'(1));
            cnt_d   = cnt_q + {15'd0, ~&cnt_q};
            state_d = stop ? HALTED : bus.step_mode ? STEP_WAIT : FETCH_I;
         end else if (timer_q == TW'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = HALTED;
         end else timer_d = timer_q + 1'b1;
         STEP_WAIT: if (bus.halt_req) state_d = HALTED;
            else if (bus.step || !bus.step_mode) state_d = FETCH_I;
         default: state_d = IDLE;
      endcase
      if (state_d == FETCH_I) mem_addr_d = pc_d;
      if (state_d == HALTED) pend_d = 1'b0;
      run_d    = state_d inside {ISSUE, EXEC};
      busy_d   = !(state_d inside {IDLE, HALTED});
      halted_d = state_d == HALTED;
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= IDLE;
         pc_q       <= '0;
         mem_addr_q <= '0;
         ir_q       <= '0;
         imm_q      <= '0;
         din_q      <= '0;
         cnt_q      <= '0;
         timer_q    <= '0;
         run_q      <= 1'b0;
         busy_q     <= 1'b0;
         halted_q   <= 1'b0;
         err_q      <= 1'b0;
         pend_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         mem_addr_q <= mem_addr_d;
         ir_q       <= ir_d;
         imm_q      <= imm_d;
         din_q      <= din_d;
         cnt_q      <= cnt_d;
         timer_q    <= timer_d;
         run_q      <= run_d;
         busy_q     <= busy_d;
         halted_q   <= halted_d;
         err_q      <= err_d;
         pend_q     <= pend_d;
      end
   end
   assign bus.mem_addr    = mem_addr_q;
   assign bus.proc_din    = din_q;
   assign bus.proc_run    = run_q;
   assign bus.pc_out      = pc_q;
   assign bus.instr_count = cnt_q;
   assign bus.busy        = busy_q;
   assign bus.halted      = halted_q;
   assign bus.timeout_err = err_q;
endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: program memory plus a processor model whose DONE delay is
// programmable; expected DIN words are queued per program and popped on each issue.
module tb_program_sequencer;
   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [8:0] mem [32];
   logic [8:0] exp_q [$];
   int         checks = 0;
   int         errors = 0;
   int         rc = 0;
   int         run_len = 0;
   int         done_at = 1;
   program_sequencer_if #(.ADDR_W(5)) bus ();
   program_sequencer #(.ADDR_W(5)) dut (.clk(clk), .resetn(resetn), .bus(bus));
   always #5 clk = ~clk;
   always_ff @(posedge clk) bus.mem_rdata <= mem[bus.mem_addr];
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   // one clock; compares DIN on ISSUE/first EXEC against the queue and drives DONE
   task automatic cycle();
      logic [31:0] e;
      @(negedge clk);
      if (bus.proc_run) rc++;
      else begin
         if (rc > 0) run_len = rc;
         rc = 0;
      end
      if (bus.proc_run && (rc == 1 || rc == 2)) begin
         e = exp_q.size() > 0 ? {23'd0, exp_q.pop_front()} : 32'hFFFF_FFFF;
         check(rc == 1 ? "issue_din" : "exec_din", {23'd0, bus.proc_din}, e);
      end
      bus.proc_done = bus.proc_run && done_at != 0 && rc == done_at + 1;
   endtask
   task automatic clear_mem();
      for (int i = 0; i < 32; i++) mem[i] = '0;
   endtask
   task automatic push2(input logic [8:0] a, input logic [8:0] b);
      exp_q.push_back(a);
      exp_q.push_back(b);
   endtask
   task automatic pulse_start();
      bus.start = 1'b1;
      cycle();
      bus.start = 1'b0;
   endtask
   task automatic wait_run(input string tag, input int exp_lat);
      int n = 0;
      while (!bus.proc_run && n < 20) begin cycle(); n++; end
      check(tag, n, exp_lat);
   endtask
   task automatic wait_idle(input string tag);
      int n = 0;
      while (bus.busy && n < 300) begin cycle(); n++; end
      check({tag, "_settle"}, {31'd0, bus.busy}, 0);
      check({tag, "_drained"}, exp_q.size(), 0);
      exp_q.delete();
   endtask
   initial begin
      bus.start = 0; bus.step_mode = 0; bus.step = 0; bus.halt_req = 0; bus.proc_done = 0;
      clear_mem();
      repeat (3) cycle();
      check("rst_pc", bus.pc_out, 0);
      check("rst_busy", {31'd0, bus.busy}, 0);
      check("rst_halted", {31'd0, bus.halted}, 0);
      check("rst_run", {31'd0, bus.proc_run}, 0);
      resetn = 1'b1;
      cycle();
      // plain mv, DONE one cycle after ISSUE
      mem[0] = 9'h04B;
      push2(9'h04B, 9'h04B);
      done_at = 1;
      pulse_start();
      wait_run("mv_latency", 2);
      wait_idle("mv");
      check("mv_pc", bus.pc_out, 1);
      check("mv_count", bus.instr_count, 1);
      check("mv_halted", {31'd0, bus.halted}, 1);
      check("mv_addr", bus.mem_addr, 1);
      check("mv_err", {31'd0, bus.timeout_err}, 0);
      check("mv_run_len", run_len, 2);
      // mvi with immediate
      clear_mem();
      mem[0] = 9'h088; mem[1] = 9'h0A5;
      push2(9'h088, 9'h0A5);
      pulse_start();
      wait_run("mvi_latency", 4);
      wait_idle("mvi");
      check("mvi_pc", bus.pc_out, 2);
      check("mvi_count", bus.instr_count, 1);
      // START and HALT_REQ together: START wins, program runs normally
      clear_mem();
      mem[0] = 9'h04B;
      push2(9'h04B, 9'h04B);
      bus.halt_req = 1'b1;
      pulse_start();
      bus.halt_req = 1'b0;
      wait_idle("start_halt");
      check("start_halt_count", bus.instr_count, 1);
      // HALT_REQ during fetch: nothing issued
      pulse_start();
      bus.halt_req = 1'b1;
      cycle();
      bus.halt_req = 1'b0;
      wait_idle("fetch_halt");
      check("fetch_halt_pc", bus.pc_out, 0);
      check("fetch_halt_count", bus.instr_count, 0);
      check("fetch_halt_halted", {31'd0, bus.halted}, 1);
      // single-step add, DONE on 3rd EXEC cycle
      clear_mem();
      mem[0] = 9'h0DA; mem[1] = 9'h0DA;
      push2(9'h0DA, 9'h0DA); push2(9'h0DA, 9'h0DA);
      done_at = 3;
      bus.step_mode = 1'b1;
      pulse_start();
      repeat (8) cycle();
      check("step_busy", {31'd0, bus.busy}, 1);
      check("step_run", {31'd0, bus.proc_run}, 0);
      check("step_pc", bus.pc_out, 1);
      check("step_addr", bus.mem_addr, 0);
      check("step_count", bus.instr_count, 1);
      check("step_run_len", run_len, 4);
      bus.step = 1'b1;
      cycle();
      bus.step = 1'b0;
      repeat (8) cycle();
      check("step2_count", bus.instr_count, 2);
      check("step2_busy", {31'd0, bus.busy}, 1);
      bus.step_mode = 1'b0;
      wait_idle("step");
      check("step_end_pc", bus.pc_out, 2);
      // sub with no DONE: timeout
      clear_mem();
      mem[0] = 9'h12E;
      push2(9'h12E, 9'h12E);
      done_at = 0;
      pulse_start();
      wait_idle("tmo");
      check("tmo_err", {31'd0, bus.timeout_err}, 1);
      check("tmo_halted", {31'd0, bus.halted}, 1);
      check("tmo_pc", bus.pc_out, 0);
      check("tmo_count", bus.instr_count, 0);
      check("tmo_run_len", run_len, 8);
      mem[0] = 9'h000;
      pulse_start();
      check("tmo_clear", {31'd0, bus.timeout_err}, 0);
      wait_idle("tmo_restart");
      // mvi at address 31 reads immediate from 0; halt together with its DONE
      clear_mem();
      mem[0] = 9'h059;
      for (int i = 1; i < 31; i++) mem[i] = 9'h041;
      mem[31] = 9'h098;
      push2(9'h059, 9'h059);
      for (int i = 1; i < 31; i++) push2(9'h041, 9'h041);
      push2(9'h098, 9'h059);
      done_at = 1;
      pulse_start();
      begin
         int n = 0;
         while (!(bus.proc_run && bus.pc_out == 5'd31) && n < 400) begin cycle(); n++; end
         check("wrap_reach", {31'd0, n < 400}, 1);
      end
      cycle();
      bus.halt_req = 1'b1;
      cycle();
      bus.halt_req = 1'b0;
      wait_idle("wrap");
      check("wrap_pc", bus.pc_out, 1);
      check("wrap_count", bus.instr_count, 32);
      check("wrap_halted", {31'd0, bus.halted}, 1);
      // asynchronous reset in the middle of EXEC
      clear_mem();
      mem[0] = 9'h12E;
      push2(9'h12E, 9'h12E);
      done_at = 0;
      pulse_start();
      begin
         int n = 0;
         while (rc != 3 && n < 20) begin cycle(); n++; end
         check("rst_reach", {31'd0, rc == 3}, 1);
      end
      #2 resetn = 1'b0;
      #1;
      check("arst_run", {31'd0, bus.proc_run}, 0);
      check("arst_din", {23'd0, bus.proc_din}, 0);
      check("arst_busy", {31'd0, bus.busy}, 0);
      check("arst_pc", bus.pc_out, 0);
      check("arst_addr", bus.mem_addr, 0);
      check("arst_count", bus.instr_count, 0);
      check("arst_halted", {31'd0, bus.halted}, 0);
      check("arst_err", {31'd0, bus.timeout_err}, 0);
      cycle();
      resetn = 1'b1;
      repeat (3) cycle();
      check("arst_idle", {31'd0, bus.busy}, 0);
      check("arst_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
